continuous_poller: RTL and testbench
====================================

# continuous_poller

Periodic read scheduler that sits between the host command decoder and the sensor control module. On a start command it issues read requests on a selected sensor channel, either once or continuously at a fixed interval. Each completed read is latched and forwarded to the host path with a one-cycle valid strobe. It generalises the fixed-width, single-sensor continuous-read block with a parametrised width, channel count and interval, a single/continuous mode, stop handling and a response watchdog.

## Interface
Parameters:
- DATA_W, 8: width of sensor data word
- NUM_CH, 32: number of addressable sensor channels; CH_W = $clog2(NUM_CH)
- PERIOD_CYC, 200_000_000: request-to-request interval in clk cycles (4 s at 50 MHz); minimum 4
- TIMEOUT_CYC, 50_000_000: maximum cycles to wait for controller completion; minimum 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle command to begin polling
- stop  in  1  one-cycle command to end continuous polling
- mode  in  1  0 = single read, 1 = continuous; captured with start
- chan_in  in  CH_W  channel to poll; captured with start
- req  out  1  one-cycle read request to the control module
- req_chan  out  CH_W  channel for req; held stable while busy
- done_ctrl  in  1  controller completion strobe
- err_ctrl  in  1  controller error flag, valid only with done_ctrl
- data_in  in  DATA_W  controller data, valid with done_ctrl
- data_out  out  DATA_W  last successfully read word
- data_valid  out  1  one-cycle strobe, data_out updated
- err  out  1  one-cycle strobe, controller error or timeout
- busy  out  1  high whenever the state is not IDLE
- cont_active  out  1  continuous mode is armed

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - start=1 and stop=0: capture mode and chan_in, set cont_active=mode, go to REQ.
  - start and stop in the same cycle: ignored.
- REQ (exactly 1 cycle): req=1 and the interval timer is cleared. Go to WAIT.
- WAIT: the timer keeps counting.
  - done_ctrl=1, err_ctrl=0: latch data_in into data_out and pulse data_valid.
  - done_ctrl=1, err_ctrl=1: pulse err; data_out is unchanged.
  - After either case, go to HOLD if cont_active, otherwise IDLE.
  - Watchdog: cycles spent in WAIT reaching TIMEOUT_CYC pulses err and takes the same exit.
- HOLD: when the timer reaches PERIOD_CYC-1, go to REQ. If that count was already passed during WAIT, go to REQ on the next cycle.
- stop, sampled in any state:
  - Clears cont_active.
  - In HOLD: go to IDLE next cycle.
  - In REQ or WAIT: the current transaction completes normally, then IDLE.
- start while busy is ignored. done_ctrl outside WAIT is ignored.
- Arithmetic: timers are $clog2(max(PERIOD_CYC, TIMEOUT_CYC))+1 bits and saturate; they never wrap.

## Timing
- Reset values: all outputs 0, state IDLE, timers 0. A reset mid-transaction returns to IDLE immediately and issues no further req.
- start sampled at edge N → req high during cycle N+1, busy high from N+1.
- done_ctrl sampled at edge M → data_out/data_valid (or err) valid in cycle M+1. The state leaves WAIT at M+1.
- Continuous mode: consecutive req rising edges are exactly PERIOD_CYC cycles apart when the controller responds within PERIOD_CYC-3 cycles. Otherwise the next req follows HOLD entry by 1 cycle.
- data_valid and err are never high together and never high for 2 consecutive cycles from the same transaction.

## Configuration
- CONT_POLLER_WATCHDOG_EN:
  - Defined: the WAIT timeout counter and the timeout err path are compiled in.
  - Undefined: WAIT exits only on done_ctrl, TIMEOUT_CYC is unused, and err reflects err_ctrl only.

## Structure
- poller_pkg: state enum (IDLE/REQ/WAIT/HOLD) and default constants for DATA_W, NUM_CH, PERIOD_CYC and TIMEOUT_CYC.
- Sub-module interval_timer:
  - Function: clear, enable, saturating up-count.
  - Outputs: count and a terminal-compare flag against a parameter.
  - Instances: one for the period; a second for the watchdog when CONT_POLLER_WATCHDOG_EN is defined.
- The FSM and data latch live in continuous_poller.

## Test plan
Use PERIOD_CYC=20, TIMEOUT_CYC=8, DATA_W=8, NUM_CH=32.
- Single read: start, mode=0, chan_in=5; controller answers done_ctrl with data_in=8'hA5 three cycles after req → one req with req_chan=5, data_out=8'hA5, one data_valid pulse, then IDLE with busy=0.
- Continuous: mode=1, replies after 2 cycles with data 8'h10, 8'h11, 8'h12 → req edges exactly 20 cycles apart and three data_valid pulses carrying those values; stop in HOLD → IDLE next cycle and no fourth req.
- Timeout (macro defined): no done_ctrl after req → err pulse 8 cycles after WAIT entry, data_out unchanged. Macro undefined → busy stays high until done_ctrl.
- Controller error: done_ctrl together with err_ctrl=1 → err pulse, no data_valid, data_out holds the previous 8'hA5.
- Stop during WAIT: stop one cycle after req, done_ctrl arrives later with data 8'h3C → data_valid with 8'h3C, then IDLE; a start issued while busy is ignored.
- Async reset: assert rst low mid-WAIT → all outputs 0 immediately; a late done_ctrl after release produces no data_valid.

Source files
------------

// File: rtl/continuous_poller_pkg.sv
// Shared types and default constants for the continuous sensor poller.
package poller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_NUM_CH      = 32;
    localparam int unsigned DEF_PERIOD_CYC  = 200_000_000;
    localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;

    // Timers must hold the larger of the two limits plus one headroom bit.
    function automatic int unsigned timer_width(input int unsigned period,
                                                input int unsigned timeout);
        int unsigned larger;
        larger = (period > timeout) ? period : timeout;
        return $clog2(larger) + 1;
    endfunction

endpackage

// File: rtl/continuous_poller_if.sv
// Host-command and sensor-controller signal bundle for the continuous poller.
interface continuous_poller_if #(
    parameter int unsigned DATA_W = poller_pkg::DEF_DATA_W,
    parameter int unsigned CH_W   = $clog2(poller_pkg::DEF_NUM_CH)
);

    logic              start;
    logic              stop;
    logic              mode;
    logic [CH_W-1:0]   chan_in;
    logic              req;
    logic [CH_W-1:0]   req_chan;
    logic              done_ctrl;
    logic              err_ctrl;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              err;
    logic              busy;
    logic              cont_active;

    // Poller side of the bundle.
    modport slave (
        input  start, stop, mode, chan_in, done_ctrl, err_ctrl, data_in,
        output req, req_chan, data_out, data_valid, err, busy, cont_active
    );

    // Host decoder / sensor controller side.
    modport master (
        output start, stop, mode, chan_in, done_ctrl, err_ctrl, data_in,
        input  req, req_chan, data_out, data_valid, err, busy, cont_active
    );

endinterface

// File: rtl/continuous_poller_interval_timer.sv
// Saturating up-counter with synchronous clear and a count >= TERM flag.
module interval_timer #(
    parameter int unsigned W    = 8,
    parameter int unsigned TERM = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         hit
);

    localparam logic [W-1:0] COUNT_MAX = '1;
    localparam logic [W-1:0] TERM_V    = W'(TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count >= TERM_V);

endmodule

// File: rtl/continuous_poller.sv
// Periodic read scheduler: single or continuous polling of one sensor channel.
// Define CONT_POLLER_WATCHDOG_EN to compile in the WAIT response watchdog.
module continuous_poller
    import poller_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    continuous_poller_if.slave bus
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned TMR_W = timer_width(PERIOD_CYC, TIMEOUT_CYC);

    state_t state;
    state_t state_nx;

    logic              cont_q;
    logic [CH_W-1:0]   chan_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              err_q;

    logic              period_clr;
    logic              period_en;
    logic              period_hit;
    logic [TMR_W-1:0]  period_count_unused;
    logic              wd_fire;

    // The timer is cleared on the REQ edge, so it reads PERIOD_CYC-2 in the
    // last HOLD cycle; leaving then puts req edges PERIOD_CYC cycles apart.
    interval_timer #(
        .W    (TMR_W),
        .TERM (PERIOD_CYC - 2)
    ) u_period (
        .clk   (clk),
        .rst   (rst),
        .clr   (period_clr),
        .en    (period_en),
        .count (period_count_unused),
        .hit   (period_hit)
    );

`ifdef CONT_POLLER_WATCHDOG_EN
    logic             wd_clr;
    logic             wd_en;
    logic             wd_hit;
    logic [TMR_W-1:0] wd_count_unused;

    interval_timer #(
        .W    (TMR_W),
        .TERM (TIMEOUT_CYC - 1)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .count (wd_count_unused),
        .hit   (wd_hit)
    );

    assign wd_fire = (state == WAIT) && wd_hit;
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.done_ctrl || wd_fire) begin
                    state_nx = (cont_q && !bus.stop) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (bus.stop) begin
                    state_nx = IDLE;
                end else if (period_hit) begin
                    state_nx = REQ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req    = (state == REQ);
        bus.busy   = (state != IDLE);
        period_clr = (state == REQ);
        period_en  = (state == WAIT) || (state == HOLD);
`ifdef CONT_POLLER_WATCHDOG_EN
        wd_clr     = (state != WAIT);
        wd_en      = (state == WAIT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cont_q  <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (bus.stop) begin
                cont_q <= 1'b0;
            end else if ((state == IDLE) && bus.start) begin
                cont_q <= bus.mode;
                chan_q <= bus.chan_in;
            end

            if (state == WAIT) begin
                if (bus.done_ctrl) begin
                    if (bus.err_ctrl) begin
                        err_q <= 1'b1;
                    end else begin
                        data_q  <= bus.data_in;
                        valid_q <= 1'b1;
                    end
                end else if (wd_fire) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_chan    = chan_q;
    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.err         = err_q;
    assign bus.cont_active = cont_q;

endmodule

// File: tb/tb_continuous_poller.sv
// Self-checking bench for continuous_poller: directed scenarios plus random traffic
// checked every cycle against an event-schedule model of the poller.
module tb_continuous_poller;

    localparam int DATA_W  = 8;
    localparam int NUM_CH  = 32;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int PERIOD  = 20;
    localparam int TIMEOUT = 8;
`ifdef CONT_POLLER_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    continuous_poller_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    continuous_poller #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Model: tracks the last req time and schedules the next one as
    // max(last_req + PERIOD, one cycle after the response was handled).
    bit              m_busy, m_cont, m_req, m_wait, m_dv, m_err;
    logic [7:0]      m_data;
    logic [CH_W-1:0] m_chan;
    int              m_wait_n, m_last_req, m_next_req;
    bit              nx_cont, nx_dv, nx_err, tmo;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 0; m_cont = 0; m_req = 0; m_wait = 0; m_dv = 0; m_err = 0;
            m_data = '0; m_chan = '0; m_wait_n = 0; m_last_req = 0; m_next_req = 0;
        end else begin
            nx_dv   = 0;
            nx_err  = 0;
            nx_cont = bus.stop ? 1'b0 : m_cont;
            if (!m_busy) begin
                if (bus.start && !bus.stop) begin
                    m_busy     = 1;
                    nx_cont    = bus.mode;
                    m_chan     = bus.chan_in;
                    m_req      = 1;
                    m_last_req = cyc + 1;
                end
            end else if (m_req) begin
                m_req    = 0;
                m_wait   = 1;
                m_wait_n = 1;
            end else if (m_wait) begin
                tmo = WD_EN && (m_wait_n >= TIMEOUT);
                if (bus.done_ctrl) begin
                    if (bus.err_ctrl) nx_err = 1;
                    else begin
                        nx_dv  = 1;
                        m_data = bus.data_in;
                    end
                end else if (tmo) begin
                    nx_err = 1;
                end
                if (bus.done_ctrl || tmo) begin
                    m_wait = 0;
                    if (nx_cont) m_next_req = imax(m_last_req + PERIOD, cyc + 2);
                    else m_busy = 0;
                end else begin
                    m_wait_n++;
                end
            end else begin
                if (bus.stop) begin
                    m_busy = 0;
                end else if (cyc + 1 == m_next_req) begin
                    m_req      = 1;
                    m_last_req = cyc + 1;
                end
            end
            m_cont = nx_cont;
            m_dv   = nx_dv;
            m_err  = nx_err;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst && chk_en) begin
            check("req",         int'(bus.req),         int'(m_req));
            check("busy",        int'(bus.busy),        int'(m_busy));
            check("cont_active", int'(bus.cont_active), int'(m_cont));
            check("data_valid",  int'(bus.data_valid),  int'(m_dv));
            check("err",         int'(bus.err),         int'(m_err));
            check("data_out",    int'(bus.data_out),    int'(m_data));
            if (m_busy) check("req_chan", int'(bus.req_chan), int'(m_chan));
        end
    end

    // Controller stand-in: answers each req after resp_k cycles (or a random delay).
    bit         resp_en = 0, resp_err = 0, rand_mode = 0;
    int         resp_k = 1;
    logic [7:0] resp_q[$];
    int         force_tok = 0;
    logic [7:0] force_data = 8'h00;
    bit         pend = 0, perr = 0;
    int         pcnt = 0, force_seen = 0;
    logic [7:0] pdata = 8'h00;

    initial begin
        bus.done_ctrl = 1'b0;
        bus.err_ctrl  = 1'b0;
        bus.data_in   = '0;
        forever begin
            @(negedge clk);
            bus.done_ctrl = 1'b0;
            bus.err_ctrl  = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    bus.done_ctrl = 1'b1;
                    bus.err_ctrl  = perr;
                    bus.data_in   = pdata;
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end else if (force_seen != force_tok) begin
                force_seen    = force_tok;
                bus.done_ctrl = 1'b1;
                bus.data_in   = force_data;
            end else if (rand_mode && $urandom_range(0, 49) == 0) begin
                bus.done_ctrl = 1'b1;
                bus.err_ctrl  = 1'($urandom_range(0, 1));
                bus.data_in   = 8'($urandom);
            end
            if (bus.req && resp_en) begin
                pend = 1;
                if (rand_mode) begin
                    pcnt  = $urandom_range(0, 25);
                    perr  = ($urandom_range(0, 4) == 0);
                    pdata = 8'($urandom);
                end else begin
                    pcnt  = resp_k - 1;
                    perr  = resp_err;
                    pdata = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                end
            end
        end
    end

    function automatic bit sig_of(input int which);
        case (which)
            0:       return bus.req;
            1:       return bus.data_valid;
            default: return bus.err;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name, output int at);
        int n;
        n  = 0;
        at = -1;
        while (!sig_of(which) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sig_of(which)) at = cyc;
        else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no event within 100 cycles, required one", name);
        end
    endtask

    task automatic pulse_start(input bit md, input int ch);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.mode    = md;
        bus.chan_in = CH_W'(ch);
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "bench time limit");
    end

    int r, d, e, cnt;
    int rq[3];

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.chan_in = '0;
        repeat (3) @(negedge clk);
        check("rst_req",   int'(bus.req),         0);
        check("rst_busy",  int'(bus.busy),        0);
        check("rst_dv",    int'(bus.data_valid),  0);
        check("rst_err",   int'(bus.err),         0);
        check("rst_data",  int'(bus.data_out),    0);
        check("rst_cont",  int'(bus.cont_active), 0);
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single read, reply 3 cycles after req.
        resp_en = 1; resp_k = 3; resp_err = 0; resp_q.push_back(8'hA5);
        pulse_start(1'b0, 5);
        wait_for(0, "t1_req", r);
        check("t1_req_chan", int'(bus.req_chan), 5);
        wait_for(1, "t1_dv", d);
        check("t1_latency", d - r, 4);
        check("t1_data", int'(bus.data_out), 8'hA5);
        @(negedge clk);
        check("t1_idle", int'(bus.busy), 0);
        repeat (3) @(negedge clk);

        // Controller error keeps the previous word.
        resp_k = 2; resp_err = 1; resp_q.push_back(8'h55);
        pulse_start(1'b0, 6);
        wait_for(2, "t2_err", e);
        check("t2_dv_low", int'(bus.data_valid), 0);
        check("t2_data_held", int'(bus.data_out), 8'hA5);
        @(negedge clk);
        check("t2_idle", int'(bus.busy), 0);
        resp_err = 0;
        repeat (3) @(negedge clk);

        // Continuous: three polls PERIOD apart, then stop in HOLD.
        resp_k = 2;
        resp_q.push_back(8'h10); resp_q.push_back(8'h11); resp_q.push_back(8'h12);
        pulse_start(1'b1, 7);
        for (int i = 0; i < 3; i++) begin
            wait_for(0, "t3_req", rq[i]);
            wait_for(1, "t3_dv", d);
            check("t3_data", int'(bus.data_out), 8'h10 + i);
        end
        check("t3_gap1", rq[1] - rq[0], PERIOD);
        check("t3_gap2", rq[2] - rq[1], PERIOD);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("t3_stop_idle", int'(bus.busy), 0);
        check("t3_stop_cont", int'(bus.cont_active), 0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.req) cnt++;
        end
        check("t3_no_4th_req", cnt, 0);

        // No controller response.
        resp_en = 0;
        pulse_start(1'b0, 2);
        wait_for(0, "t4_req", r);
        if (WD_EN) begin
            wait_for(2, "t4_timeout_err", e);
            check("t4_timeout_lat", e - r, 9);
            check("t4_data_held", int'(bus.data_out), 8'h12);
            @(negedge clk);
            check("t4_idle", int'(bus.busy), 0);
        end else begin
            cnt = 0;
            repeat (30) begin
                @(negedge clk);
                if (!bus.busy) cnt++;
            end
            check("t4_busy_held", cnt, 0);
            force_data = 8'h77;
            force_tok++;
            wait_for(1, "t4_late_dv", d);
            check("t4_late_data", int'(bus.data_out), 8'h77);
            @(negedge clk);
            check("t4_idle", int'(bus.busy), 0);
        end
        resp_en = 1;
        repeat (3) @(negedge clk);

        // Stop during WAIT, plus an ignored start while busy.
        resp_k = 5; resp_q.push_back(8'h3C);
        pulse_start(1'b1, 9);
        wait_for(0, "t5_req", r);
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        bus.start = 1'b1; bus.mode = 1'b0; bus.chan_in = CH_W'(3);
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_cont_cleared", int'(bus.cont_active), 0);
        wait_for(1, "t5_dv", d);
        check("t5_data", int'(bus.data_out), 8'h3C);
        check("t5_chan_kept", int'(bus.req_chan), 9);
        check("t5_idle", int'(bus.busy), 0);
        repeat (3) @(negedge clk);

        // Async reset in WAIT; the late reply must be ignored.
        resp_k = 6; resp_q.push_back(8'hE1);
        pulse_start(1'b0, 4);
        wait_for(0, "t6_req", r);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_req",  int'(bus.req),         0);
        check("t6_rst_busy", int'(bus.busy),        0);
        check("t6_rst_dv",   int'(bus.data_valid),  0);
        check("t6_rst_err",  int'(bus.err),         0);
        check("t6_rst_data", int'(bus.data_out),    0);
        check("t6_rst_cont", int'(bus.cont_active), 0);
        check("t6_rst_chan", int'(bus.req_chan),    0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.data_valid || bus.req) cnt++;
        end
        check("t6_no_late_activity", cnt, 0);

        // Random traffic against the model.
        rand_mode = 1;
        repeat (3000) begin
            @(negedge clk);
            bus.start   = ($urandom_range(0, 19) == 0);
            bus.stop    = ($urandom_range(0, 39) == 0);
            bus.mode    = 1'($urandom_range(0, 1));
            bus.chan_in = CH_W'($urandom_range(0, NUM_CH - 1));
        end
        @(negedge clk);
        bus.start = 0;
        bus.stop  = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
